ex_stage: RTL and testbench

Execute stage of the pipelined LEGv8 CPU, sitting directly downstream of the ID/EX pipeline register. It consumes the `*_ex` operand and control values and forwards operands from the MEM and WB stages. It computes the ALU or BL-link result, maintains the architectural NZCV flags register, and registers its results into the EX/MEM pipeline register (`*_mem` outputs). It also exports a same-cycle `lt_fwd` flag so ID can resolve B.LT without waiting for the flag write.

---
 rtl/ex_stage.sv | 145 ++++++++++++++
 tb/tb_ex_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: LEGv8 execute stage. Forwards operands from MEM/WB, runs the
// ALU or selects the BL link value, keeps the NZCV flags register and
// registers results into the EX/MEM pipeline register.
module ex_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        hold,
   input  logic [63:0] Da_ex,
   input  logic [63:0] Db_ex,
   input  logic [63:0] ALU_or_DT_ex,
   input  logic [63:0] BLT_ex,
   input  logic [4:0]  Rn_ex,
   input  logic [4:0]  Ab_ex,
   input  logic [4:0]  Rd_ex,
   input  logic [2:0]  ALUop_ex,
   input  logic        ALUsrc_ex,
   input  logic        update_ex,
   input  logic        BLsignal_ex,
   input  logic        RegWrite_ex,
   input  logic        MemtoReg_ex,
   input  logic        MemWrite_ex,
   input  logic [3:0]  xfer_size_ex,
   input  logic        RegWrite_wb,
   input  logic [4:0]  Rd_wb,
   input  logic [63:0] Wd_wb,
   output logic [63:0] alu_result_mem,
   output logic [63:0] store_data_mem,
   output logic [4:0]  Rd_mem,
   output logic [3:0]  xfer_size_mem,
   output logic        RegWrite_mem,
   output logic        MemtoReg_mem,
   output logic        MemWrite_mem,
   output logic        flag_n,
   output logic        flag_z,
   output logic        flag_c,
   output logic        flag_v,
   output logic        lt_fwd
);

   logic [63:0] a_op;
   logic [63:0] bf_op;
   logic [63:0] b_op;
   logic [64:0] sum65;
   logic [63:0] alu_res;
   logic [63:0] result;
   logic        n_alu;
   logic        z_alu;
   logic        c_alu;
   logic        v_alu;

   // Operand A: XZR never forwards; MEM (non-load) beats WB.
   always_comb begin
      a_op = Da_ex;
      if (Rn_ex != 5'd31) begin
         if (RegWrite_mem && (Rd_mem == Rn_ex) && !MemtoReg_mem)
            a_op = alu_result_mem;
         else if (RegWrite_wb && (Rd_wb == Rn_ex))
            a_op = Wd_wb;
      end
   end

   // Operand B before the immediate mux; also the store data.
   always_comb begin
      bf_op = Db_ex;
      if (Ab_ex != 5'd31) begin
         if (RegWrite_mem && (Rd_mem == Ab_ex) && !MemtoReg_mem)
            bf_op = alu_result_mem;
         else if (RegWrite_wb && (Rd_wb == Ab_ex))
            bf_op = Wd_wb;
      end
   end

   assign b_op = ALUsrc_ex ? ALU_or_DT_ex : bf_op;

   // ALU: subtraction is A + ~B + 1 so carry means "no borrow".
   always_comb begin
      sum65   = '0;
      alu_res = '0;
      c_alu   = 1'b0;
      v_alu   = 1'b0;
      case (ALUop_ex)
         3'b000: alu_res = b_op;
         3'b010: begin
            sum65   = {1'b0, a_op} + {1'b0, b_op};
            alu_res = sum65[63:0];
            c_alu   = sum65[64];
            v_alu   = (a_op[63] == b_op[63]) && (alu_res[63] != a_op[63]);
         end
         3'b011: begin
            sum65   = {1'b0, a_op} + {1'b0, ~b_op} + 65'd1;
            alu_res = sum65[63:0];
            c_alu   = sum65[64];
            v_alu   = (a_op[63] != b_op[63]) && (alu_res[63] != a_op[63]);
         end
         3'b100: alu_res = a_op & b_op;
         3'b101: alu_res = a_op | b_op;
         3'b110: alu_res = a_op ^ b_op;
         default: alu_res = '0;
      endcase
   end

   assign n_alu  = alu_res[63];
   assign z_alu  = (alu_res == 64'd0);
   assign result = BLsignal_ex ? BLT_ex : alu_res;

   // Lets ID resolve B.LT against a flag setter still sitting in EX.
   assign lt_fwd = update_ex ? (n_alu ^ v_alu) : (flag_n ^ flag_v);

   // Flags register: reset beats hold, hold beats update.
   always_ff @(posedge clk) begin
      if (reset) begin
         flag_n <= 1'b0;
         flag_z <= 1'b0;
         flag_c <= 1'b0;
         flag_v <= 1'b0;
      end else if (update_ex && !hold) begin
         flag_n <= n_alu;
         flag_z <= z_alu;
         flag_c <= c_alu;
         flag_v <= v_alu;
      end
   end

   // EX/MEM pipeline register, frozen during a memory stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_result_mem <= '0;
         store_data_mem <= '0;
         Rd_mem         <= '0;
         xfer_size_mem  <= '0;
         RegWrite_mem   <= 1'b0;
         MemtoReg_mem   <= 1'b0;
         MemWrite_mem   <= 1'b0;
      end else if (!hold) begin
         alu_result_mem <= result;
         store_data_mem <= bf_op;
         Rd_mem         <= Rd_ex;
         xfer_size_mem  <= xfer_size_ex;
         RegWrite_mem   <= RegWrite_ex;
         MemtoReg_mem   <= MemtoReg_ex;
         MemWrite_mem   <= MemWrite_ex;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed checks of the execute stage.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        reset, hold;
   logic [63:0] Da_ex, Db_ex, ALU_or_DT_ex, BLT_ex;
   logic [4:0]  Rn_ex, Ab_ex, Rd_ex;
   logic [2:0]  ALUop_ex;
   logic        ALUsrc_ex, update_ex, BLsignal_ex;
   logic        RegWrite_ex, MemtoReg_ex, MemWrite_ex;
   logic [3:0]  xfer_size_ex;
   logic        RegWrite_wb;
   logic [4:0]  Rd_wb;
   logic [63:0] Wd_wb;
   logic [63:0] alu_result_mem, store_data_mem;
   logic [4:0]  Rd_mem;
   logic [3:0]  xfer_size_mem;
   logic        RegWrite_mem, MemtoReg_mem, MemWrite_mem;
   logic        flag_n, flag_z, flag_c, flag_v, lt_fwd;

   int total = 0;
   int bad   = 0;

   ex_stage dut (
      .clk(clk), .reset(reset), .hold(hold),
      .Da_ex(Da_ex), .Db_ex(Db_ex), .ALU_or_DT_ex(ALU_or_DT_ex), .BLT_ex(BLT_ex),
      .Rn_ex(Rn_ex), .Ab_ex(Ab_ex), .Rd_ex(Rd_ex), .ALUop_ex(ALUop_ex),
      .ALUsrc_ex(ALUsrc_ex), .update_ex(update_ex), .BLsignal_ex(BLsignal_ex),
      .RegWrite_ex(RegWrite_ex), .MemtoReg_ex(MemtoReg_ex), .MemWrite_ex(MemWrite_ex),
      .xfer_size_ex(xfer_size_ex), .RegWrite_wb(RegWrite_wb), .Rd_wb(Rd_wb), .Wd_wb(Wd_wb),
      .alu_result_mem(alu_result_mem), .store_data_mem(store_data_mem), .Rd_mem(Rd_mem),
      .xfer_size_mem(xfer_size_mem), .RegWrite_mem(RegWrite_mem),
      .MemtoReg_mem(MemtoReg_mem), .MemWrite_mem(MemWrite_mem),
      .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .lt_fwd(lt_fwd)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // All-zero control: a bubble with no forwarding from WB.
   task automatic idle();
      Da_ex = '0; Db_ex = '0; ALU_or_DT_ex = '0; BLT_ex = '0;
      Rn_ex = 5'd0; Ab_ex = 5'd0; Rd_ex = 5'd0; ALUop_ex = 3'b000;
      ALUsrc_ex = 0; update_ex = 0; BLsignal_ex = 0;
      RegWrite_ex = 0; MemtoReg_ex = 0; MemWrite_ex = 0; xfer_size_ex = 4'd0;
      RegWrite_wb = 0; Rd_wb = 5'd0; Wd_wb = '0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1; hold = 0;
      tick();
      reset = 0;
      total++; if (alu_result_mem !== 64'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", alu_result_mem); end
      total++; if (store_data_mem !== 64'd0) begin bad++; $display("FAIL reset_store got=%h exp=0", store_data_mem); end
      total++; if ({Rd_mem, xfer_size_mem, RegWrite_mem, MemtoReg_mem, MemWrite_mem} !== 12'd0) begin
         bad++; $display("FAIL reset_ctrl got=%h exp=0", {Rd_mem, xfer_size_mem, RegWrite_mem, MemtoReg_mem, MemWrite_mem}); end
      total++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0000) begin
         bad++; $display("FAIL reset_flags got=%b exp=0000", {flag_n, flag_z, flag_c, flag_v}); end
   endtask

   task automatic test_subs_flags();
      // 3 - 5
      idle();
      Rn_ex = 5'd1; Da_ex = 64'd3; Ab_ex = 5'd2; Db_ex = 64'd5;
      ALUop_ex = 3'b011; update_ex = 1; Rd_ex = 5'd9;
      #1;
      total++; if (lt_fwd !== 1'b1) begin bad++; $display("FAIL subs_lt_fwd got=%b exp=1", lt_fwd); end
      tick();
      total++; if (alu_result_mem !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL subs_result got=%h exp=fffffffffffffffe", alu_result_mem); end
      total++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b1000) begin
         bad++; $display("FAIL subs_flags got=%b exp=1000", {flag_n, flag_z, flag_c, flag_v}); end
      // 0x8000... - 1: signed overflow, no borrow
      Da_ex = 64'h8000_0000_0000_0000; Db_ex = 64'd1;
      #1;
      total++; if (lt_fwd !== 1'b1) begin bad++; $display("FAIL subs_ovf_lt_fwd got=%b exp=1", lt_fwd); end
      tick();
      total++; if (alu_result_mem !== 64'h7FFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL subs_ovf_result got=%h exp=7fffffffffffffff", alu_result_mem); end
      total++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0011) begin
         bad++; $display("FAIL subs_ovf_flags got=%b exp=0011", {flag_n, flag_z, flag_c, flag_v}); end
   endtask

   task automatic test_add();
      idle();
      Rn_ex = 5'd1; Da_ex = 64'd5; Ab_ex = 5'd2; Db_ex = 64'd7;
      ALUop_ex = 3'b010; RegWrite_ex = 1; Rd_ex = 5'd3;
      #1;
      // no flag update: lt_fwd reflects stored N^V = 0^1
      total++; if (lt_fwd !== 1'b1) begin bad++; $display("FAIL add_lt_fwd got=%b exp=1", lt_fwd); end
      tick();
      total++; if (alu_result_mem !== 64'd12) begin bad++; $display("FAIL add_result got=%0d exp=12", alu_result_mem); end
      total++; if (Rd_mem !== 5'd3 || RegWrite_mem !== 1'b1) begin bad++; $display("FAIL add_ctrl got=%0d/%b exp=3/1", Rd_mem, RegWrite_mem); end
      total++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0011) begin
         bad++; $display("FAIL add_flags_kept got=%b exp=0011", {flag_n, flag_z, flag_c, flag_v}); end
   endtask

   task automatic test_logic();
      logic [2:0]  ops [6];
      logic [63:0] exp [6];
      ops[0] = 3'b100; exp[0] = 64'hF000;
      ops[1] = 3'b101; exp[1] = 64'hFFF0;
      ops[2] = 3'b110; exp[2] = 64'h0FF0;
      ops[3] = 3'b000; exp[3] = 64'hFF00;
      ops[4] = 3'b111; exp[4] = 64'h0;
      ops[5] = 3'b001; exp[5] = 64'h0;
      for (int i = 0; i < 6; i++) begin
         idle();
         Rn_ex = 5'd10; Da_ex = 64'hF0F0; Ab_ex = 5'd11; Db_ex = 64'hFF00;
         ALUop_ex = ops[i]; RegWrite_ex = 1; Rd_ex = 5'd12; update_ex = 1;
         tick();
         total++; if (alu_result_mem !== exp[i]) begin bad++; $display("FAIL logic_op%0d got=%h exp=%h", ops[i], alu_result_mem, exp[i]); end
         total++; if ({flag_n, flag_z, flag_c, flag_v} !== {1'b0, exp[i] == 64'd0, 2'b00}) begin
            bad++; $display("FAIL logic_flags_op%0d got=%b exp=%b", ops[i], {flag_n, flag_z, flag_c, flag_v}, {1'b0, exp[i] == 64'd0, 2'b00}); end
      end
   endtask

   task automatic test_forwarding();
      // X3 = 4 + 5 = 9
      idle();
      Rn_ex = 5'd1; Da_ex = 64'd4; Ab_ex = 5'd2; Db_ex = 64'd5;
      ALUop_ex = 3'b010; RegWrite_ex = 1; Rd_ex = 5'd3;
      tick();
      // X7 = X3 + X3, MEM (9) beats WB (4) and the stale file value
      idle();
      Rn_ex = 5'd3; Da_ex = 64'd100; Ab_ex = 5'd3; Db_ex = 64'd100;
      RegWrite_wb = 1; Rd_wb = 5'd3; Wd_wb = 64'd4;
      ALUop_ex = 3'b010; RegWrite_ex = 1; Rd_ex = 5'd7;
      tick();
      total++; if (alu_result_mem !== 64'd18) begin bad++; $display("FAIL fwd_mem_prio got=%0d exp=18", alu_result_mem); end
      // A from WB (X3=4), B from MEM (X7=18)
      idle();
      Rn_ex = 5'd3; Da_ex = 64'd100; Ab_ex = 5'd7; Db_ex = 64'd1;
      RegWrite_wb = 1; Rd_wb = 5'd3; Wd_wb = 64'd4;
      ALUop_ex = 3'b010; RegWrite_ex = 1; Rd_ex = 5'd31;
      tick();
      total++; if (alu_result_mem !== 64'd22) begin bad++; $display("FAIL fwd_wb_and_mem got=%0d exp=22", alu_result_mem); end
      // MEM writes X31 (22), WB writes X31: reads of X31 take the file value 0
      idle();
      Rn_ex = 5'd31; Ab_ex = 5'd31;
      RegWrite_wb = 1; Rd_wb = 5'd31; Wd_wb = 64'h77;
      ALUop_ex = 3'b010; RegWrite_ex = 1; Rd_ex = 5'd31;
      tick();
      total++; if (alu_result_mem !== 64'd0) begin bad++; $display("FAIL fwd_xzr got=%h exp=0", alu_result_mem); end
   endtask

   task automatic test_store();
      idle();
      Rn_ex = 5'd5; Da_ex = 64'h2000; Ab_ex = 5'd4; Db_ex = 64'h0;
      RegWrite_wb = 1; Rd_wb = 5'd4; Wd_wb = 64'h100;
      ALUsrc_ex = 1; ALU_or_DT_ex = 64'd8; ALUop_ex = 3'b010;
      MemWrite_ex = 1; xfer_size_ex = 4'b1000; Rd_ex = 5'd4;
      tick();
      total++; if (alu_result_mem !== 64'h2008) begin bad++; $display("FAIL stur_addr got=%h exp=2008", alu_result_mem); end
      total++; if (store_data_mem !== 64'h100) begin bad++; $display("FAIL stur_data got=%h exp=100", store_data_mem); end
      total++; if ({MemWrite_mem, RegWrite_mem, xfer_size_mem} !== 6'b10_1000) begin
         bad++; $display("FAIL stur_ctrl got=%b exp=101000", {MemWrite_mem, RegWrite_mem, xfer_size_mem}); end
   endtask

   task automatic test_bl();
      idle();
      BLsignal_ex = 1; BLT_ex = 64'h44; Rd_ex = 5'd30; RegWrite_ex = 1;
      Da_ex = 64'h5; Db_ex = 64'h6; Rn_ex = 5'd1; Ab_ex = 5'd2; ALUop_ex = 3'b010;
      tick();
      total++; if (alu_result_mem !== 64'h44) begin bad++; $display("FAIL bl_result got=%h exp=44", alu_result_mem); end
      total++; if (Rd_mem !== 5'd30 || RegWrite_mem !== 1'b1) begin bad++; $display("FAIL bl_ctrl got=%0d/%b exp=30/1", Rd_mem, RegWrite_mem); end
   endtask

   task automatic test_back_to_back();
      idle();
      Rn_ex = 5'd1; Da_ex = 64'd3; Ab_ex = 5'd2; Db_ex = 64'd5;
      ALUop_ex = 3'b011; update_ex = 1; Rd_ex = 5'd9;
      tick();
      total++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b1000) begin
         bad++; $display("FAIL b2b_first got=%b exp=1000", {flag_n, flag_z, flag_c, flag_v}); end
      Da_ex = 64'd1; Db_ex = 64'd1; ALUop_ex = 3'b010;
      tick();
      total++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0000) begin
         bad++; $display("FAIL b2b_second got=%b exp=0000", {flag_n, flag_z, flag_c, flag_v}); end
      Da_ex = 64'd5; Db_ex = 64'd5; ALUop_ex = 3'b011;
      tick();
      total++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0110) begin
         bad++; $display("FAIL b2b_third got=%b exp=0110", {flag_n, flag_z, flag_c, flag_v}); end
      // bubble
      idle();
      tick();
      total++; if ({RegWrite_mem, MemWrite_mem} !== 2'b00) begin bad++; $display("FAIL bubble_ctrl got=%b exp=00", {RegWrite_mem, MemWrite_mem}); end
      total++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0110) begin
         bad++; $display("FAIL bubble_flags got=%b exp=0110", {flag_n, flag_z, flag_c, flag_v}); end
   endtask

   task automatic test_hold_reset();
      idle();
      Rn_ex = 5'd1; Da_ex = 64'd3; Ab_ex = 5'd2; Db_ex = 64'd5;
      ALUop_ex = 3'b011; update_ex = 1; RegWrite_ex = 1; Rd_ex = 5'd9;
      tick();
      hold = 1;
      for (int i = 0; i < 3; i++) begin
         Da_ex = 64'd100 + 64'(i); Db_ex = 64'd1; Rd_ex = 5'(20 + i); MemWrite_ex = 1;
         tick();
         total++; if (alu_result_mem !== 64'hFFFF_FFFF_FFFF_FFFE || Rd_mem !== 5'd9 || MemWrite_mem !== 1'b0) begin
            bad++; $display("FAIL hold_regs%0d got=%h/%0d/%b exp=fffffffffffffffe/9/0", i, alu_result_mem, Rd_mem, MemWrite_mem); end
         total++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b1000) begin
            bad++; $display("FAIL hold_flags%0d got=%b exp=1000", i, {flag_n, flag_z, flag_c, flag_v}); end
      end
      reset = 1;
      tick();
      reset = 0; hold = 0;
      total++; if ({alu_result_mem, store_data_mem} !== 128'd0 || {Rd_mem, RegWrite_mem, MemWrite_mem} !== 7'd0) begin
         bad++; $display("FAIL hold_reset_regs got=%h/%h/%0d exp=0", alu_result_mem, store_data_mem, Rd_mem); end
      total++; if ({flag_n, flag_z, flag_c, flag_v} !== 4'b0000) begin
         bad++; $display("FAIL hold_reset_flags got=%b exp=0000", {flag_n, flag_z, flag_c, flag_v}); end
      idle();
      #1;
      total++; if (lt_fwd !== 1'b0) begin bad++; $display("FAIL post_reset_lt got=%b exp=0", lt_fwd); end
   endtask

   initial begin
      reset = 1; hold = 0;
      idle();
      test_reset();
      test_subs_flags();
      test_add();
      test_logic();
      test_forwarding();
      test_store();
      test_bl();
      test_back_to_back();
      test_hold_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
